// File: rtl/targ_rx_pkt_ctrl.sv
// UART receive packet controller: frames bytes into packets and
// buffers them in a byte FIFO for the host, with error accounting.
//
// Ports:
//   clk, reset       rising-edge clock, async active-high reset
//   rx_data          received byte
//   rx_data_ready    pulse, rx_data valid
//   rx_data_error    pulse, framing error (byte discarded)
//   rx_endofpacket   pulse, line gap closes the current packet
//   enable           level, 0 drops bytes and parks the FSM
//   clear            pulse, clears sticky flags, err_count, FIFO
//   rd_en            host pop request
//   rd_data/rd_valid popped byte and its one-cycle strobe
//   fifo_count/empty FIFO occupancy
//   pkt_done/pkt_len packet close pulse and held length
//   overflow         sticky, byte dropped on a full FIFO
//   pkt_too_long     sticky, packet exceeded MAX_PKT
//   err_count        saturating framing error count
module targ_rx_pkt_ctrl #(
   parameter int DEPTH_LOG2 = 4,
   parameter int MAX_PKT    = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_data_ready,
   input  logic                  rx_data_error,
   input  logic                  rx_endofpacket,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  rd_en,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   output logic [DEPTH_LOG2:0]   fifo_count,
   output logic                  fifo_empty,
   output logic                  pkt_done,
   output logic [7:0]            pkt_len,
   output logic                  overflow,
   output logic                  pkt_too_long,
   output logic [7:0]            err_count
);

   localparam int Depth = 1 << DEPTH_LOG2;
   localparam logic [7:0] MaxLen = 8'(MAX_PKT);
   localparam logic [DEPTH_LOG2:0] CntFull = (DEPTH_LOG2 + 1)'(Depth);
   localparam logic [DEPTH_LOG2:0] CntOne = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PtrOne = DEPTH_LOG2'(1);

   typedef enum logic [1:0] {
      Disabled,
      WaitPkt,
      InPkt,
      Discard
   } state_t;

   state_t state;
   state_t stateNext;

   logic [7:0]            mem [Depth];
   logic [DEPTH_LOG2-1:0] wrPtr;
   logic [DEPTH_LOG2-1:0] rdPtr;
   logic [DEPTH_LOG2:0]   count;
   logic [7:0]            lenCnt;

   logic                  byteIn;
   logic                  setTooLong;
   logic                  closePkt;
   logic [7:0]            closeLen;
   logic [7:0]            lenNext;

   logic                  full;
   logic                  popOk;
   logic                  doPop;
   logic                  doPush;
   logic                  setOvf;
   logic                  errEvt;
   logic [7:0]            errBase;

   // state register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= Disabled;
      end else begin
         state <= stateNext;
      end
   end

   // next-state logic
   always_comb begin
      stateNext = state;
      if (!enable) begin
         stateNext = Disabled;
      end else begin
         unique case (state)
            Disabled: stateNext = WaitPkt;
            WaitPkt:  if (rx_data_ready) stateNext = InPkt;
            InPkt: begin
               if (rx_endofpacket) stateNext = WaitPkt;
               else if (setTooLong) stateNext = Discard;
            end
            Discard:  if (rx_endofpacket) stateNext = WaitPkt;
         endcase
      end
   end

   // output / datapath decisions
   always_comb begin
      byteIn     = 1'b0;
      setTooLong = 1'b0;
      closePkt   = 1'b0;
      closeLen   = lenCnt;
      lenNext    = lenCnt;
      if (!enable) begin
         // an aborted packet never reports its length
         lenNext = 8'd0;
      end else begin
         unique case (state)
            Disabled: lenNext = 8'd0;
            WaitPkt: begin
               if (rx_data_ready) begin
                  byteIn  = 1'b1;
                  lenNext = 8'd1;
               end
            end
            InPkt: begin
               if (rx_data_ready) begin
                  if (lenCnt == MaxLen) begin
                     setTooLong = 1'b1;
                  end else begin
                     byteIn  = 1'b1;
                     lenNext = lenCnt + 8'd1;
                  end
               end
               if (rx_endofpacket) begin
                  closePkt = 1'b1;
                  closeLen = setTooLong ? MaxLen : lenNext;
                  lenNext  = 8'd0;
               end
            end
            Discard: begin
               if (rx_endofpacket) begin
                  closePkt = 1'b1;
                  closeLen = MaxLen;
                  lenNext  = 8'd0;
               end
            end
         endcase
      end
   end

   // a pop frees a slot for a same-cycle push even when full
   assign full   = (count == CntFull);
   assign popOk  = rd_en && (count != '0);
   assign doPop  = popOk && !clear;
   assign doPush = byteIn && (!full || popOk) && !clear;
   assign setOvf = byteIn && full && !popOk;
   assign errEvt = rx_data_error && (state != Disabled);
   assign errBase = clear ? 8'd0 : err_count;

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= rx_data;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr        <= '0;
         rdPtr        <= '0;
         count        <= '0;
         lenCnt       <= 8'd0;
         rd_data      <= 8'h00;
         rd_valid     <= 1'b0;
         pkt_done     <= 1'b0;
         pkt_len      <= 8'd0;
         overflow     <= 1'b0;
         pkt_too_long <= 1'b0;
         err_count    <= 8'd0;
      end else begin
         lenCnt   <= lenNext;
         rd_valid <= doPop;
         pkt_done <= closePkt;
         if (closePkt) pkt_len <= closeLen;
         if (doPop) rd_data <= mem[rdPtr];
         if (clear) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
         end else begin
            if (doPush) wrPtr <= wrPtr + PtrOne;
            if (doPop) rdPtr <= rdPtr + PtrOne;
            if (doPush && !doPop) count <= count + CntOne;
            else if (!doPush && doPop) count <= count - CntOne;
         end
         // a set event beats a coincident clear
         overflow     <= (overflow && !clear) || setOvf;
         pkt_too_long <= (pkt_too_long && !clear) || setTooLong;
         if (errEvt && errBase != 8'hFF) err_count <= errBase + 8'd1;
         else err_count <= errBase;
      end
   end

   assign fifo_count = count;
   assign fifo_empty = (count == '0);

endmodule

// File: doc/targ_rx_pkt_ctrl.md
TARG_RX_PKT_CTRL -- requirements
Module: targ_rx_pkt_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, meaning the byte FIFO holds 2^DEPTH_LOG2 entries.
REQ-002 SHALL have parameter MAX_PKT, default 64, meaning the maximum accepted packet length in bytes (1..255).
REQ-003 clk  in  1  single clock; all logic is rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 rx_data  in  8  received byte from the UART receiver.
REQ-006 rx_data_ready  in  1  one-cycle pulse; rx_data is valid.
REQ-007 rx_data_error  in  1  one-cycle pulse; stop bit missing, byte discarded.
REQ-008 rx_endofpacket  in  1  one-cycle pulse; line gap ends the current packet.
REQ-009 enable  in  1  level; 0 discards all incoming bytes and holds the FSM in DISABLED.
REQ-010 clear  in  1  one-cycle pulse; clears sticky flags, error count and FIFO.
REQ-011 rd_en  in  1  host pop request.
REQ-012 rd_data  out  8  FIFO head byte (registered, valid the cycle after an accepted pop).
REQ-013 rd_valid  out  1  one-cycle pulse with rd_data.
REQ-014 fifo_count  out  DEPTH_LOG2+1  bytes currently stored.
REQ-015 fifo_empty  out  1  fifo_count==0.
REQ-016 pkt_done  out  1  one-cycle pulse at packet close.
REQ-017 pkt_len  out  8  length of the last closed packet, held until the next close.
REQ-018 overflow  out  1  sticky; a byte was dropped because the FIFO was full.
REQ-019 pkt_too_long  out  1  sticky; a packet exceeded MAX_PKT.
REQ-020 err_count  out  8  framing errors seen, saturating at 255.

Function
REQ-021 SHALL implement FSM states DISABLED, WAIT_PKT, IN_PKT, DISCARD.
REQ-022 DISABLED -> WAIT_PKT when enable=1; any state -> DISABLED the cycle after enable=0, with the in-progress length dropped and no pkt_done.
REQ-023 WAIT_PKT -> IN_PKT on rx_data_ready; the byte is pushed and len_cnt is set to 1.
REQ-024 IN_PKT: each rx_data_ready pushes the byte and increments len_cnt; rx_endofpacket -> WAIT_PKT with pkt_done=1 and pkt_len=len_cnt on the next cycle.
REQ-025 IN_PKT: an rx_data_ready when len_cnt==MAX_PKT is not pushed, sets pkt_too_long and goes to DISCARD.
REQ-026 DISCARD: bytes are ignored; rx_endofpacket -> WAIT_PKT with pkt_done=1 and pkt_len=MAX_PKT.
REQ-027 rx_endofpacket in WAIT_PKT or DISABLED SHALL be ignored (no pkt_done).
REQ-028 rx_data_error SHALL increment err_count (saturating) in every state except DISABLED, push nothing, and leave the FSM state unchanged.
REQ-029 A push when fifo_count==2^DEPTH_LOG2 and no pop that cycle SHALL drop the byte and set overflow; len_cnt still increments.
REQ-030 Push and pop in the same cycle when full SHALL both succeed; fifo_count unchanged, overflow not set.
REQ-031 Push and pop in the same cycle when empty: the push succeeds, the pop is ignored, and rd_valid=0.
REQ-032 rd_en while empty SHALL be ignored; rd_data holds its previous value.
REQ-033 FIFO pointers SHALL be DEPTH_LOG2 bits wide and wrap modulo 2^DEPTH_LOG2.
REQ-034 Sticky flags, err_count and FIFO contents SHALL clear on clear.
REQ-035 clear coincident with a push SHALL leave the FIFO empty.
REQ-036 clear coincident with a set event SHALL leave the sticky flags set.
REQ-037 clear coincident with an error SHALL leave err_count=1.
REQ-038 clear SHALL NOT change FSM state or len_cnt.

Reset
REQ-039 On reset: FSM=DISABLED; pointers, fifo_count, len_cnt, pkt_len, err_count=0; fifo_empty=1.
REQ-040 On reset: rd_valid, pkt_done, overflow, pkt_too_long=0; rd_data=8'h00.
REQ-041 Reset asserted mid-packet SHALL abort the packet with no pkt_done; the first packet after reset is received intact.

Verification
REQ-042 enable=1, bytes 0x11,0x22,0x33 then endofpacket -> pkt_done once, pkt_len=3; three pops return 0x11,0x22,0x33 in order; fifo_empty=1 afterwards.
REQ-043 DEPTH_LOG2=4, 17 bytes with no pops -> fifo_count=16, overflow=1; pops return bytes 1..16; pkt_len=17.
REQ-044 MAX_PKT=4, 6-byte packet -> 4 bytes stored, pkt_too_long=1, pkt_len=4; the next 2-byte packet gives pkt_len=2.
REQ-045 260 rx_data_error pulses -> err_count=255; clear -> err_count=0.
REQ-046 Full FIFO with simultaneous push and rd_en -> fifo_count stays 16, overflow=0; rd_en on empty -> rd_valid=0, rd_data unchanged.
REQ-047 Reset asserted after 2 bytes of a packet, then a 1-byte packet -> fifo_count=1, pkt_len=1, single pkt_done.
